// File: rtl/ysyx_22040931_ex_mdu_pkg.sv
// Shared encodings for the EX-stage MDU: op codes, FSM states and op-decode helpers.
// Pure declarations, no logic or timing of its own.
package ysyx_22040931_ex_mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MUL   = 3'd1;
    localparam logic [2:0] MDU_MULH  = 3'd2;
    localparam logic [2:0] MDU_MULHU = 3'd3;
    localparam logic [2:0] MDU_DIV   = 3'd4;
    localparam logic [2:0] MDU_DIVU  = 3'd5;
    localparam logic [2:0] MDU_REM   = 3'd6;
    localparam logic [2:0] MDU_REMU  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } ex_state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // MULH/MULHU take the upper product half; REM/REMU take the remainder register.
    function automatic logic op_sel_hi(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHU) || (op == MDU_REM) || (op == MDU_REMU);
    endfunction

endpackage

// File: rtl/ysyx_22040931_mdu_iter.sv
// Iterative 1-bit/cycle shift-add multiplier / restoring divider on operand magnitudes.
// XLEN steps after start; o_done/o_result are valid during the final step cycle, no backpressure.
module ysyx_22040931_mdu_iter
    import ysyx_22040931_ex_mdu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int CNTW = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    logic            r_busy;
    logic [CNTW-1:0] r_cnt;
    logic            r_is_div;
    logic            r_sel_hi;
    logic            r_neg;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opb;

    logic              w_sgn, w_neg1, w_neg2, w_neg_res, w_div;
    logic [XLEN-1:0]   w_abs1, w_abs2;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN-1:0]   w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_hi_n, w_lo_n;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0]   w_div_sel, w_div_fix;

    assign w_sgn     = op_is_signed(i_op);
    assign w_div     = op_is_div(i_op);
    assign w_neg1    = w_sgn & i_src1[XLEN-1];
    assign w_neg2    = w_sgn & i_src2[XLEN-1];
    assign w_abs1    = w_neg1 ? -i_src1 : i_src1;
    assign w_abs2    = w_neg2 ? -i_src2 : i_src2;
    // Remainder follows the dividend sign; quotient and product follow the sign product.
    assign w_neg_res = (w_div & op_sel_hi(i_op)) ? w_neg1 : (w_neg1 ^ w_neg2);

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_shift   = {r_hi, r_lo[XLEN-1]};
    assign w_ge      = (w_shift >= {1'b0, r_opb});
    assign w_diff    = w_shift[XLEN-1:0] - r_opb;

    assign w_hi_n = r_is_div ? (w_ge ? w_diff : w_shift[XLEN-1:0]) : w_mul_sum[XLEN:1];
    assign w_lo_n = r_is_div ? {r_lo[XLEN-2:0], w_ge} : {w_mul_sum[0], r_lo[XLEN-1:1]};

    assign w_prod     = {w_hi_n, w_lo_n};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_div_sel  = r_sel_hi ? w_hi_n : w_lo_n;
    assign w_div_fix  = r_neg ? -w_div_sel : w_div_sel;

    assign o_done   = r_busy & (r_cnt == CNTW'(XLEN-1));
    assign o_result = r_is_div ? w_div_fix
                    : (r_sel_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sel_hi <= 1'b0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= w_div;
            r_sel_hi <= op_sel_hi(i_op);
            r_neg    <= w_neg_res;
            r_hi     <= '0;
            r_lo     <= w_div ? w_abs1 : w_abs2;
            r_opb    <= w_div ? w_abs2 : w_abs1;
        end else if (r_busy) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + CNTW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/ysyx_22040931_ex_mdu.sv
// EX stage: ALU pass-through or iterative RV64M op, registered result toward EX/MEM.
// ALU/special cases 1 cycle, mul/div XLEN+1 cycles; holds payload while mem_ready low, ex_ready low while busy.
module ysyx_22040931_ex_mdu
    import ysyx_22040931_ex_mdu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int CNTW = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            id_valid,
    output logic            ex_ready,
    input  logic [63:0]     in_pc,
    input  logic            in_w_ena,
    input  logic [4:0]      in_w_addr,
    input  logic [2:0]      in_mdu_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [XLEN-1:0] in_alu_res,
    output logic            ex_valid,
    input  logic            mem_ready,
    output logic [63:0]     out_pc,
    output logic            out_w_ena,
    output logic [4:0]      out_w_addr,
    output logic [XLEN-1:0] out_result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    ex_state_t       r_state, w_state_nxt;
    logic [63:0]     r_pc;
    logic            r_w_ena;
    logic [4:0]      r_w_addr;
    logic [XLEN-1:0] r_result;

    logic            w_accept, w_fast, w_special, w_div_zero, w_ovf;
    logic [XLEN-1:0] w_special_res;
    logic            w_iter_done;
    logic [XLEN-1:0] w_iter_res;

    assign w_accept   = id_valid & ex_ready & ~flush;
    assign w_div_zero = (in_src2 == '0);
    assign w_ovf      = op_is_signed(in_mdu_op) & (in_src1 == MIN_NEG) & (in_src2 == '1);
    assign w_special  = op_is_div(in_mdu_op) & (w_div_zero | w_ovf);
    assign w_fast     = (in_mdu_op == MDU_NONE) | w_special;

    // Divide-by-zero and signed overflow resolve without iterating.
    assign w_special_res = w_div_zero
        ? (((in_mdu_op == MDU_DIV) | (in_mdu_op == MDU_DIVU)) ? '1 : in_src1)
        : ((in_mdu_op == MDU_DIV) ? in_src1 : '0);

    ysyx_22040931_mdu_iter #(
        .XLEN (XLEN),
        .CNTW (CNTW)
    ) u_iter (
        .clock    (clock),
        .reset    (reset),
        .i_flush  (flush),
        .i_start  (w_accept & ~w_fast),
        .i_op     (in_mdu_op),
        .i_src1   (in_src1),
        .i_src2   (in_src2),
        .o_done   (w_iter_done),
        .o_result (w_iter_res)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_state_nxt = w_fast ? ST_HOLD : ST_BUSY;
                ST_BUSY: if (w_iter_done) w_state_nxt = ST_HOLD;
                ST_HOLD: if (mem_ready) w_state_nxt = w_accept ? (w_fast ? ST_HOLD : ST_BUSY) : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ex_ready = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & mem_ready);
        ex_valid = (r_state == ST_HOLD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc     <= '0;
            r_w_ena  <= 1'b0;
            r_w_addr <= '0;
            r_result <= '0;
        end else if (!flush) begin
            if (w_accept) begin
                r_pc     <= in_pc;
                r_w_ena  <= in_w_ena;
                r_w_addr <= in_w_addr;
                if (in_mdu_op == MDU_NONE) r_result <= in_alu_res;
                else if (w_special)        r_result <= w_special_res;
            end else if ((r_state == ST_BUSY) && w_iter_done) begin
                r_result <= w_iter_res;
            end
        end
    end

    assign out_pc     = r_pc;
    assign out_w_ena  = r_w_ena;
    assign out_w_addr = r_w_addr;
    assign out_result = r_result;

endmodule

// File: tb/tb_ysyx_22040931_ex_mdu.sv
// Scoreboard bench for the EX-stage MDU: expected results queued at issue, popped when ex_valid appears.
module tb_ysyx_22040931_ex_mdu;
    import ysyx_22040931_ex_mdu_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] res;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, flush, id_valid, ex_ready, in_w_ena, ex_valid, mem_ready, out_w_ena;
    logic [63:0] in_pc, in_src1, in_src2, in_alu_res, out_pc, out_result;
    logic [4:0]  in_w_addr, out_w_addr;
    logic [2:0]  in_mdu_op;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clock = ~clock;

    ysyx_22040931_ex_mdu #(.XLEN(64), .CNTW(7)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .id_valid   (id_valid),
        .ex_ready   (ex_ready),
        .in_pc      (in_pc),
        .in_w_ena   (in_w_ena),
        .in_w_addr  (in_w_addr),
        .in_mdu_op  (in_mdu_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_alu_res (in_alu_res),
        .ex_valid   (ex_valid),
        .mem_ready  (mem_ready),
        .out_pc     (out_pc),
        .out_w_ena  (out_w_ena),
        .out_w_addr (out_w_addr),
        .out_result (out_result)
    );

    // Called at a negedge with ex_ready high; the following posedge accepts the op.
    task automatic send(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                        input logic [63:0] alu, input logic [63:0] pc);
        in_mdu_op  = op;
        in_src1    = s1;
        in_src2    = s2;
        in_alu_res = alu;
        in_pc      = pc;
        in_w_ena   = 1'b1;
        in_w_addr  = pc[6:2];
        id_valid   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        id_valid   = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc <= budget) begin
            if (ex_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; id_valid = 1'b0; mem_ready = 1'b1;
        in_pc = '0; in_w_ena = 1'b0; in_w_addr = '0; in_mdu_op = MDU_NONE;
        in_src1 = '0; in_src2 = '0; in_alu_res = '0;
        repeat (3) @(negedge clock);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
        checks++; if (out_result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", out_result); end
        checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if ({out_w_ena, out_w_addr} !== 6'h0) begin errors++; $display("FAIL reset_wb: got %b/%h want 0/0", out_w_ena, out_w_addr); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_alu();
        int cyc; bit ok; exp_t e;
        repeat (3) @(negedge clock);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", ex_valid); end
        sb_q.push_back({64'h8c, 64'h1234});
        send(MDU_NONE, 64'h5, 64'h6, 64'h1234, 64'h8c);
        wait_valid(10, cyc, ok);
        checks++; if (!ok || cyc != 0) begin errors++; $display("FAIL alu_latency: got %0d (seen %b) want 0", cyc, ok); end
        e = sb_q.pop_front();
        checks++; if ({out_pc, out_result} !== e) begin errors++; $display("FAIL alu_result: got %h/%h want %h/%h", out_pc, out_result, e.pc, e.res); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL alu_ex_ready: got %b want 1", ex_ready); end
        checks++; if ({out_w_ena, out_w_addr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL alu_wb: got %b/%h want 1/03", out_w_ena, out_w_addr); end
        @(negedge clock);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL alu_drain: got %b want 0", ex_valid); end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{MDU_MUL, MDU_MULHU, MDU_MULH, MDU_MUL};
        logic [63:0] a   [4] = '{64'd7, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h1_0000_0001};
        logic [63:0] b   [4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'd2, 64'h1_0000_0001};
        logic [63:0] r   [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2_0000_0001};
        int cyc; bit ok; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({64'h1000 + 64'(i * 4), r[i]});
            send(ops[i], a[i], b[i], 64'h0, 64'h1000 + 64'(i * 4));
            checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL mul%0d_busy_ready: got %b want 0", i, ex_ready); end
            wait_valid(100, cyc, ok);
            checks++; if (!ok || cyc != 64) begin errors++; $display("FAIL mul%0d_latency: got %0d (seen %b) want 64", i, cyc, ok); end
            e = sb_q.pop_front();
            checks++; if ({out_pc, out_result} !== e) begin errors++; $display("FAIL mul%0d_result: got %h/%h want %h/%h", i, out_pc, out_result, e.pc, e.res); end
            @(negedge clock);
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [6] = '{MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU, MDU_DIV, MDU_REM};
        logic [63:0] a   [6] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100, 64'd7, 64'd7};
        logic [63:0] b   [6] = '{64'd2, 64'd2, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
        logic [63:0] r   [6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
        int cyc; bit ok; exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back({64'h2000 + 64'(i * 4), r[i]});
            send(ops[i], a[i], b[i], 64'h0, 64'h2000 + 64'(i * 4));
            wait_valid(100, cyc, ok);
            checks++; if (!ok || cyc != 64) begin errors++; $display("FAIL div%0d_latency: got %0d (seen %b) want 64", i, cyc, ok); end
            e = sb_q.pop_front();
            checks++; if ({out_pc, out_result} !== e) begin errors++; $display("FAIL div%0d_result: got %h/%h want %h/%h", i, out_pc, out_result, e.pc, e.res); end
            @(negedge clock);
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  ops [6] = '{MDU_DIVU, MDU_REM, MDU_DIV, MDU_REM, MDU_DIV, MDU_REMU};
        logic [63:0] a   [6] = '{64'd12345, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                 64'hFFFF_FFFF_FFFF_FFF7, 64'd77};
        logic [63:0] b   [6] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
        logic [63:0] r   [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000, 64'd0,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'd77};
        int cyc; bit ok; exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back({64'h3000 + 64'(i * 4), r[i]});
            send(ops[i], a[i], b[i], 64'h0, 64'h3000 + 64'(i * 4));
            wait_valid(100, cyc, ok);
            checks++; if (!ok || cyc != 0) begin errors++; $display("FAIL special%0d_latency: got %0d (seen %b) want 0", i, cyc, ok); end
            e = sb_q.pop_front();
            checks++; if ({out_pc, out_result} !== e) begin errors++; $display("FAIL special%0d_result: got %h/%h want %h/%h", i, out_pc, out_result, e.pc, e.res); end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok; exp_t e, a;
        mem_ready = 1'b0;
        sb_q.push_back({64'h200, 64'hAAAA});
        send(MDU_NONE, 64'h0, 64'h0, 64'hAAAA, 64'h200);
        wait_valid(10, cyc, ok);
        a = sb_q.pop_front();
        checks++; if (!ok || {out_pc, out_result} !== a) begin errors++; $display("FAIL bp_first: got %h/%h want %h/%h", out_pc, out_result, a.pc, a.res); end
        // A competing op waits at the input while the output is stalled.
        in_mdu_op = MDU_NONE; in_alu_res = 64'hDEAD; in_pc = 64'h2f0; id_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if ({ex_valid, ex_ready, out_pc, out_result} !== {1'b1, 1'b0, a}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b r=%b %h/%h want v=1 r=0 %h/%h", i, ex_valid, ex_ready, out_pc, out_result, a.pc, a.res);
            end
        end
        mem_ready = 1'b1;
        in_alu_res = 64'hBBBB; in_pc = 64'h204; in_w_addr = 5'd1;
        sb_q.push_back({64'h204, 64'hBBBB});
        @(posedge clock);
        @(negedge clock);
        e = sb_q.pop_front();
        checks++; if ({ex_valid, out_pc, out_result} !== {1'b1, e}) begin errors++; $display("FAIL b2b_alu: got v=%b %h/%h want v=1 %h/%h", ex_valid, out_pc, out_result, e.pc, e.res); end
        in_mdu_op = MDU_MUL; in_src1 = 64'd6; in_src2 = 64'd7; in_pc = 64'h208;
        sb_q.push_back({64'h208, 64'd42});
        @(posedge clock);
        @(negedge clock);
        id_valid = 1'b0;
        checks++; if ({ex_valid, ex_ready} !== 2'b00) begin errors++; $display("FAIL b2b_busy: got v=%b r=%b want v=0 r=0", ex_valid, ex_ready); end
        wait_valid(100, cyc, ok);
        checks++; if (!ok || cyc != 64) begin errors++; $display("FAIL b2b_mul_latency: got %0d (seen %b) want 64", cyc, ok); end
        e = sb_q.pop_front();
        checks++; if ({out_pc, out_result} !== e) begin errors++; $display("FAIL b2b_mul_result: got %h/%h want %h/%h", out_pc, out_result, e.pc, e.res); end
        @(negedge clock);
    endtask

    task automatic test_flush();
        int cyc; bit ok; exp_t e; int seen;
        send(MDU_MUL, 64'h100_0000_0000, 64'd3, 64'h0, 64'h400);
        repeat (29) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checks++; if ({ex_valid, ex_ready} !== 2'b01) begin errors++; $display("FAIL flush_state: got v=%b r=%b want v=0 r=1", ex_valid, ex_ready); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (ex_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_stale_valid: got %0d valid cycles want 0", seen); end
        sb_q.push_back({64'h404, 64'd15});
        send(MDU_MUL, 64'd3, 64'd5, 64'h0, 64'h404);
        wait_valid(100, cyc, ok);
        checks++; if (!ok || cyc != 64) begin errors++; $display("FAIL flush_mul_latency: got %0d (seen %b) want 64", cyc, ok); end
        e = sb_q.pop_front();
        checks++; if ({out_pc, out_result} !== e) begin errors++; $display("FAIL flush_mul_result: got %h/%h want %h/%h", out_pc, out_result, e.pc, e.res); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_busy();
        int cyc; bit ok; exp_t e;
        send(MDU_DIVU, 64'd1000, 64'd3, 64'h0, 64'h500);
        repeat (20) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_ready, out_result, out_pc, out_w_ena, out_w_addr} !== {1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 5'h0}) begin
            errors++;
            $display("FAIL rst_busy: got v=%b r=%b %h/%h wb=%b/%h want v=0 r=1 0/0 wb=0/0", ex_valid, ex_ready, out_result, out_pc, out_w_ena, out_w_addr);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sb_q.push_back({64'h504, 64'd100});
        send(MDU_DIVU, 64'd1000, 64'd10, 64'h0, 64'h504);
        wait_valid(100, cyc, ok);
        checks++; if (!ok || cyc != 64) begin errors++; $display("FAIL rst_div_latency: got %0d (seen %b) want 64", cyc, ok); end
        e = sb_q.pop_front();
        checks++; if ({out_pc, out_result} !== e) begin errors++; $display("FAIL rst_div_result: got %h/%h want %h/%h", out_pc, out_result, e.pc, e.res); end
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_div_special();
        test_back_to_back();
        test_flush();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
